// File: rtl/vga_fb_arbiter_pkg.sv
// vga_fb_pkg: shared constants and types for the VGA frame-buffer arbiter.
//   PIX_W/WORD_W  : one SRAM word carries two 24-bit pixels
//   H_ACT/V_ACT   : visible raster, FB_WORDS is the frame size in words
//   tag_e         : owner of an outstanding SRAM read
//   state_e       : display prefetch FSM states
package vga_fb_pkg;

  localparam int PIX_W    = 24;
  localparam int WORD_W   = 48;
  localparam int H_ACT    = 640;
  localparam int V_ACT    = 480;
  localparam int FB_WORDS = H_ACT * V_ACT / 2;
  localparam int ADDR_W   = 18;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [PIX_W-1:0]  pix_t;

  typedef enum logic {
    TAG_DISP,
    TAG_HOST
  } tag_e;

  typedef enum logic [1:0] {
    SYNC,
    FILL,
    RUN
  } state_e;

  // Even (left) pixel lives in the low half, odd pixel in the high half.
  function automatic pix_t word_half(input word_t w, input logic odd);
    return odd ? w[WORD_W-1:PIX_W] : w[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: host access port of the frame-buffer arbiter.
//   host_req/we/addr/wdata : request, held stable by the host until host_gnt
//   host_gnt               : one-cycle grant, the access uses the SRAM this cycle
//   host_rdata/host_rvalid : read return, one cycle after the grant of a read
// master = host side, slave = arbiter side.
interface vga_fb_arbiter_if;
  import vga_fb_pkg::*;

  logic                  host_req;
  logic                  host_we;
  logic [ADDR_W-1:0]     host_addr;
  word_t                 host_wdata;
  logic                  host_gnt;
  word_t                 host_rdata;
  logic                  host_rvalid;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid
  );

endinterface

// File: rtl/vga_fb_arbiter_fifo.sv
// fb_word_fifo: DEPTH x WIDTH register FIFO for display prefetch words.
//   gclk/rst_clk : clock, async active-high reset
//   flush        : synchronous clear of pointers and count
//   push/din     : write a word (ignored when full)
//   pop          : drop the head word (ignored when empty)
//   head         : current head word, straight from storage
//   count        : registered occupancy, 0..DEPTH
// DEPTH must be at least 2.
module fb_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             gclk,
  input  logic             rst_clk,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic                        wr_en, rd_en;

  assign wr_en = push && (count != CNT_W'(DEPTH));
  assign rd_en = pop && (count != '0);
  assign head  = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge gclk or posedge rst_clk) begin
    if (rst_clk) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: schedules one single-port 1-cycle-latency SRAM between the
// VGA display path (prefetched into a small word FIFO) and a host port.
//   gclk, rst_clk      : 25 MHz pixel clock, async active-high reset
//   de, vs             : active video and vertical sync (low = sync pulse)
//   pix_data           : pixel for the timing controller, same cycle as de
//   underrun           : sticky, de seen while the FIFO was empty
//   host               : host request/grant/read-return port (slave side)
//   mem_*              : SRAM strobe, write enable, address, data in/out
// The display takes a slot whenever the FIFO plus its outstanding read would
// still fit; every other slot is offered to the host.
module vga_fb_arbiter #(
  parameter int FB_WORDS   = vga_fb_pkg::FB_WORDS,
  parameter int ADDR_W     = vga_fb_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          gclk,
  input  logic                          rst_clk,
  input  logic                          de,
  input  logic                          vs,
  output logic [vga_fb_pkg::PIX_W-1:0]  pix_data,
  output logic                          underrun,
  vga_fb_arbiter_if.slave               host,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [vga_fb_pkg::WORD_W-1:0] mem_wdata,
  input  logic [vga_fb_pkg::WORD_W-1:0] mem_rdata
);
  import vga_fb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] disp_addr;
  logic              rd_vld;
  tag_e              rd_tag;
  logic              half;
  logic              underrun_q;

  logic              disp_win, host_win, disp_inflight;
  logic              push, pop, flush, fifo_empty;
  word_t             head;
  logic [CNT_W-1:0]  count;
  int                occ_nxt;

  // ---------------------------------------------------------------------------
  // Slot arbitration. At most one display read is ever in flight (latency 1),
  // so occupancy plus that read is the exact number of words already claimed.
  // ---------------------------------------------------------------------------
  assign disp_inflight = rd_vld && (rd_tag == TAG_DISP);
  assign disp_win      = (state != SYNC) &&
                         (int'(count) + int'(disp_inflight) < FIFO_DEPTH);
  // Gated by reset so a host holding req through reset sees no grant.
  assign host_win      = !disp_win && host.host_req && !rst_clk;

  // Display returns that straddle entry into SYNC are dropped here.
  assign push       = disp_inflight && (state != SYNC);
  assign flush      = (state == SYNC);
  assign fifo_empty = (count == '0);
  assign pop        = de && half && !fifo_empty;
  assign occ_nxt    = int'(count) + int'(push) - int'(pop);

  fb_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .gclk    (gclk),
    .rst_clk (rst_clk),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .din     (mem_rdata),
    .head    (head),
    .count   (count)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge gclk or posedge rst_clk) begin
    if (rst_clk) state <= SYNC;
    else         state <= state_nxt;
  end

  // RUN is taken on the edge that lands the last fill word, hence occ_nxt.
  always_comb begin
    state_nxt = state;
    if (!vs) begin
      state_nxt = SYNC;
    end else begin
      case (state)
        SYNC:    state_nxt = FILL;
        FILL:    if (occ_nxt >= FIFO_DEPTH) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_win) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (host_win) begin
      mem_en   = 1'b1;
      mem_we   = host.host_we;
      mem_addr = host.host_addr;
      if (host.host_we) mem_wdata = host.host_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return tag, display address, pixel half select, underrun flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge gclk or posedge rst_clk) begin
    if (rst_clk) begin
      rd_vld     <= 1'b0;
      rd_tag     <= TAG_DISP;
      disp_addr  <= '0;
      half       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rd_vld <= mem_en && !mem_we;
      rd_tag <= disp_win ? TAG_DISP : TAG_HOST;
      // Cleared while de is low so every line starts on the even pixel.
      half   <= de ? ~half : 1'b0;
      if (de && fifo_empty) underrun_q <= 1'b1;
      if (state == SYNC)
        disp_addr <= '0;
      else if (disp_win)
        disp_addr <= (disp_addr == ADDR_W'(FB_WORDS - 1)) ? '0 : disp_addr + 1'b1;
    end
  end

  assign pix_data = (de && !fifo_empty) ? word_half(head, half) : '0;
  assign underrun = underrun_q;

  assign host.host_gnt    = host_win;
  assign host.host_rvalid = rd_vld && (rd_tag == TAG_HOST);
  assign host.host_rdata  = host.host_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  localparam int FBW   = 600;   // shortened frame so a wrap fits in the run
  localparam int DEPTH = 4;

  logic        gclk = 1'b0;
  logic        rst_clk = 1'b1;
  logic        de = 1'b0;
  logic        vs = 1'b0;
  logic [23:0] pix_data;
  logic        underrun;
  logic        mem_en, mem_we;
  logic [17:0] mem_addr;
  logic [47:0] mem_wdata;
  logic [47:0] mem_rdata = '0;

  int n_chk  = 0;
  int n_pass = 0;
  int pix_idx = 0;

  logic [47:0] sram [0:1023];

  vga_fb_arbiter_if host ();

  vga_fb_arbiter #(
    .FB_WORDS   (FBW),
    .ADDR_W     (18),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .gclk      (gclk),
    .rst_clk   (rst_clk),
    .de        (de),
    .vs        (vs),
    .pix_data  (pix_data),
    .underrun  (underrun),
    .host      (host),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 gclk = ~gclk;

  // SRAM environment: single port, read data one cycle after the strobe.
  always @(posedge gclk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr[9:0]];
    end
  end

  // Reference pixel stream: word k holds pixel k in the even half and k with
  // bit 23 set in the odd half, so a swapped half is visible.
  function automatic logic [23:0] exp_pix(input int p);
    logic [23:0] v;
    v = 24'((p / 2) % FBW);
    if (p % 2 == 1) v[23] = 1'b1;
    return v;
  endfunction

  function automatic logic [142:0] all_outs();
    return {pix_data, underrun, host.host_gnt, host.host_rvalid, host.host_rdata,
            mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  task automatic test_reset();
    rst_clk = 1'b1; vs = 1'b0; de = 1'b0;
    host.host_req = 1'b0; host.host_we = 1'b0;
    host.host_addr = '0; host.host_wdata = '0;
    repeat (2) @(negedge gclk);
    #1;
    n_chk++;
    if (all_outs() !== '0) $display("FAIL reset_outs got=%h exp=0", all_outs());
    else n_pass++;
    n_chk++;
    if (dut.state !== SYNC) $display("FAIL reset_state got=%0d exp=%0d", dut.state, SYNC);
    else n_pass++;
    n_chk++;
    if (dut.disp_addr !== '0 || dut.u_fifo.count !== '0)
      $display("FAIL reset_addr_cnt addr=%0d cnt=%0d exp=0/0", dut.disp_addr, dut.u_fifo.count);
    else n_pass++;
  endtask

  task automatic test_fill();
    state_e exp_st;
    @(negedge gclk);
    rst_clk = 1'b0; vs = 1'b1; pix_idx = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge gclk); #1;
      if (i <= 4) begin
        n_chk++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 18'(i - 1)})
          $display("FAIL fill_rd%0d got en=%b we=%b addr=%0d exp=1/0/%0d", i, mem_en, mem_we, mem_addr, i - 1);
        else n_pass++;
      end else if (i == 5) begin
        n_chk++;
        if (mem_en !== 1'b0) $display("FAIL fill_full_idle got mem_en=%b exp=0", mem_en);
        else n_pass++;
      end
      exp_st = (i == 6) ? RUN : FILL;
      n_chk++;
      if (dut.state !== exp_st) $display("FAIL fill_state c%0d got=%0d exp=%0d", i, dut.state, exp_st);
      else n_pass++;
      n_chk++;
      if (pix_data !== '0) $display("FAIL fill_pix c%0d got=%h exp=0", i, pix_data);
      else n_pass++;
    end
  endtask

  task automatic test_active_line();
    repeat (4) @(negedge gclk);
    for (int p = 0; p < 640; p++) begin
      @(negedge gclk); de = 1'b1; #1;
      n_chk++;
      if (pix_data !== exp_pix(pix_idx)) $display("FAIL line_pix p=%0d got=%h exp=%h", pix_idx, pix_data, exp_pix(pix_idx));
      else n_pass++;
      n_chk++;
      if (underrun !== 1'b0) $display("FAIL line_underrun p=%0d got=%b exp=0", pix_idx, underrun);
      else n_pass++;
      pix_idx++;
    end
    @(negedge gclk); de = 1'b0; #1;
    n_chk++;
    if (pix_data !== '0) $display("FAIL blank_pix got=%h exp=0", pix_data);
    else n_pass++;
  endtask

  task automatic test_host_contention();
    logic [47:0] exp_wr [64];
    bit          wr_ok  [64];
    int          off, gap;
    bit          adv, got;
    for (int i = 0; i < 64; i++) begin exp_wr[i] = '0; wr_ok[i] = 1'b0; end
    repeat (4) @(negedge gclk);
    gap = 0; adv = 1'b1; off = 0;
    for (int p = 0; p < 640; p++) begin
      @(negedge gclk);
      de = 1'b1;
      if (adv) begin
        off = int'($urandom_range(0, 63));
        host.host_req   = 1'b1;
        host.host_we    = 1'b1;
        host.host_addr  = 18'(FBW + off);
        host.host_wdata = {16'($urandom), 32'($urandom)};
      end
      #1;
      n_chk++;
      if (pix_data !== exp_pix(pix_idx)) $display("FAIL cont_pix p=%0d got=%h exp=%h", pix_idx, pix_data, exp_pix(pix_idx));
      else n_pass++;
      pix_idx++;
      if (host.host_gnt === 1'b1) begin
        n_chk++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, host.host_addr, host.host_wdata})
          $display("FAIL cont_wr_bus got en=%b we=%b a=%0d d=%h exp a=%0d d=%h", mem_en, mem_we, mem_addr, mem_wdata, host.host_addr, host.host_wdata);
        else n_pass++;
        exp_wr[off] = host.host_wdata; wr_ok[off] = 1'b1;
        gap = 0; adv = 1'b1;
      end else begin
        gap++; adv = 1'b0;
      end
      n_chk++;
      if (gap > 1) $display("FAIL cont_gap p=%0d got=%0d idle cycles exp<=1", p, gap);
      else n_pass++;
    end
    @(negedge gclk); de = 1'b0; host.host_req = 1'b0;

    for (int o = 0; o < 64; o++) begin
      if (wr_ok[o]) begin
        @(negedge gclk);
        host.host_req = 1'b1; host.host_we = 1'b0; host.host_addr = 18'(FBW + o);
        got = 1'b0;
        for (int w = 0; w < 8; w++) begin
          if (w > 0) @(negedge gclk);
          #1;
          if (host.host_gnt === 1'b1) begin got = 1'b1; break; end
        end
        n_chk++;
        if (!got) $display("FAIL rd_gnt_timeout addr=%0d got no gnt exp gnt within 8", FBW + o);
        else n_pass++;
        n_chk++;
        if (host.host_rvalid !== 1'b0) $display("FAIL rd_rvalid_early got=%b exp=0", host.host_rvalid);
        else n_pass++;
        @(negedge gclk); host.host_req = 1'b0; #1;
        n_chk++;
        if (host.host_rvalid !== 1'b1 || host.host_rdata !== exp_wr[o])
          $display("FAIL rd_data addr=%0d got v=%b d=%h exp v=1 d=%h", FBW + o, host.host_rvalid, host.host_rdata, exp_wr[o]);
        else n_pass++;
        @(negedge gclk); #1;
        n_chk++;
        if (host.host_rvalid !== 1'b0) $display("FAIL rd_rvalid_late got=%b exp=0", host.host_rvalid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_frame_wrap();
    int  exp_rd, last_rd, blank, n_sync;
    bit  saw_wrap, got;
    repeat (6) @(negedge gclk);
    // FIFO is full and idle: the display is DEPTH words ahead of the pixels.
    exp_rd   = (pix_idx / 2 + DEPTH) % FBW;
    last_rd  = -1;
    saw_wrap = 1'b0;
    for (int line = 0; line < 2; line++) begin
      blank = int'($urandom_range(8, 30));
      for (int c = 0; c < blank + 640; c++) begin
        @(negedge gclk); de = (c >= blank); #1;
        if (mem_en === 1'b1 && mem_we === 1'b0 && host.host_gnt === 1'b0) begin
          n_chk++;
          if (int'(mem_addr) != exp_rd) $display("FAIL wrap_rd_addr got=%0d exp=%0d", mem_addr, exp_rd);
          else n_pass++;
          if (int'(mem_addr) == 0 && last_rd == FBW - 1) saw_wrap = 1'b1;
          last_rd = int'(mem_addr);
          exp_rd  = (exp_rd + 1) % FBW;
        end
        if (de) begin
          n_chk++;
          if (pix_data !== exp_pix(pix_idx)) $display("FAIL wrap_pix p=%0d got=%h exp=%h", pix_idx, pix_data, exp_pix(pix_idx));
          else n_pass++;
          pix_idx++;
        end
      end
    end
    @(negedge gclk); de = 1'b0;
    n_chk++;
    if (!saw_wrap) $display("FAIL wrap_seen got=0 exp=1 (read %0d then 0)", FBW - 1);
    else n_pass++;

    // vs low pulse: no display traffic, FIFO flushed, restart at word 0.
    vs = 1'b0;
    n_sync = int'($urandom_range(3, 10));
    for (int i = 0; i < n_sync; i++) begin
      @(negedge gclk); #1;
      n_chk++;
      if (mem_en !== 1'b0) $display("FAIL sync_idle i=%0d got mem_en=%b exp=0", i, mem_en);
      else n_pass++;
    end
    n_chk++;
    if (dut.u_fifo.count !== '0) $display("FAIL sync_flush got=%0d exp=0", dut.u_fifo.count);
    else n_pass++;
    @(negedge gclk); vs = 1'b1; pix_idx = 0;
    got = 1'b0;
    for (int w = 0; w < 8; w++) begin
      @(negedge gclk); #1;
      if (mem_en === 1'b1) begin got = 1'b1; break; end
    end
    n_chk++;
    if (!got || mem_addr !== '0) $display("FAIL new_frame_addr got en=%b addr=%0d exp 1/0", got, mem_addr);
    else n_pass++;
    repeat (8) @(negedge gclk);
    for (int p = 0; p < 16; p++) begin
      @(negedge gclk); de = 1'b1; #1;
      n_chk++;
      if (pix_data !== exp_pix(pix_idx)) $display("FAIL new_frame_pix p=%0d got=%h exp=%h", pix_idx, pix_data, exp_pix(pix_idx));
      else n_pass++;
      pix_idx++;
    end
    @(negedge gclk); de = 1'b0;
  endtask

  task automatic test_underrun();
    @(negedge gclk); rst_clk = 1'b1; vs = 1'b0; de = 1'b0;
    @(negedge gclk); rst_clk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge gclk); de = 1'b1; #1;
      n_chk++;
      if (pix_data !== '0) $display("FAIL ur_pix i=%0d got=%h exp=0", i, pix_data);
      else n_pass++;
      n_chk++;
      if (underrun !== (i > 0)) $display("FAIL ur_flag i=%0d got=%b exp=%b", i, underrun, (i > 0));
      else n_pass++;
    end
    @(negedge gclk); de = 1'b0; vs = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge gclk); #1;
      n_chk++;
      if (underrun !== 1'b1) $display("FAIL ur_sticky i=%0d got=%b exp=1", i, underrun);
      else n_pass++;
    end
    @(negedge gclk); rst_clk = 1'b1; #1;
    n_chk++;
    if (underrun !== 1'b0) $display("FAIL ur_reset got=%b exp=0", underrun);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    bit got;
    @(negedge gclk); rst_clk = 1'b0; vs = 1'b1;
    repeat (10) @(negedge gclk);
    host.host_req = 1'b1; host.host_we = 1'b0; host.host_addr = 18'(FBW + 1);
    got = 1'b0;
    for (int w = 0; w < 8; w++) begin
      if (w > 0) @(negedge gclk);
      #1;
      if (host.host_gnt === 1'b1) begin got = 1'b1; break; end
    end
    n_chk++;
    if (!got) $display("FAIL mid_gnt_timeout got no gnt exp gnt within 8");
    else n_pass++;
    // Reset lands before the edge that would launch the read return.
    rst_clk = 1'b1; host.host_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge gclk); #1;
      n_chk++;
      if (all_outs() !== '0) $display("FAIL mid_outs i=%0d got=%h exp=0", i, all_outs());
      else n_pass++;
      n_chk++;
      if (dut.state !== SYNC) $display("FAIL mid_state i=%0d got=%0d exp=%0d", i, dut.state, SYNC);
      else n_pass++;
    end
    @(negedge gclk); rst_clk = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) sram[k] = {24'(k) | 24'h800000, 24'(k)};
    test_reset();
    test_fill();
    test_active_line();
    test_host_contention();
    test_frame_wrap();
    test_underrun();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
